// File: rtl/fc_out_sequencer.sv
// Serialises the eight lane results of the fully-connected output mux into the
// output buffer, with optional ReLU, over a valid/ready write handshake.
module fc_out_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  relu_en,
  output logic [3:0]            mux_sel,
  input  logic [DATA_WIDTH-1:0] mux_out,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  relu_q, relu_d;
  logic [3:0]            mux_sel_q, mux_sel_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next-state and registered-output logic; every output is computed from the
  // next state so busy/done line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    base_d     = base_q;
    relu_d     = relu_q;
    mux_sel_d  = mux_sel_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d    = base_addr;
          relu_d    = relu_en;
          k_d       = 4'd1;
          mux_sel_d = 4'd1;
          state_d   = S_FETCH;
        end else begin
          mux_sel_d = 4'd0;
        end
      end
      S_FETCH: begin
        // Lane k sits at base + (k-1); the add wraps modulo the buffer size.
        wr_data_d  = (relu_q && mux_out[DATA_WIDTH-1]) ? {DATA_WIDTH{1'b0}} : mux_out;
        wr_addr_d  = base_q + ADDR_WIDTH'(k_q - 4'd1);
        wr_valid_d = 1'b1;
        mux_sel_d  = 4'd0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (wr_valid_q && wr_ready) begin
          wr_valid_d = 1'b0;
          if (k_q == 4'd8) begin
            state_d = S_DONE;
          end else begin
            k_d       = k_q + 4'd1;
            mux_sel_d = k_q + 4'd1;
            state_d   = S_FETCH;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        mux_sel_d  = 4'd0;
        wr_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= 4'd1;
      base_q     <= {ADDR_WIDTH{1'b0}};
      relu_q     <= 1'b0;
      mux_sel_q  <= 4'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= {ADDR_WIDTH{1'b0}};
      wr_data_q  <= {DATA_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      base_q     <= base_d;
      relu_q     <= relu_d;
      mux_sel_q  <= mux_sel_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fc_out_sequencer.sv
// Scoreboard bench for fc_out_sequencer: a lane-table mux model feeds the DUT,
// expected buffer writes are queued per pass and checked by a separate monitor.
module tb_fc_out_sequencer;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          relu_en;
  logic [3:0]    mux_sel;
  logic [DW-1:0] mux_out;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  fc_out_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .relu_en(relu_en),
    .mux_sel(mux_sel), .mux_out(mux_out), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // Mux model: lane table indexed by select code, junk for "no lane".
  logic [DW-1:0] lanes [8];
  assign mux_out = (mux_sel >= 4'd1 && mux_sel <= 4'd8) ? lanes[3'(mux_sel - 4'd1)] : 16'hBAD0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] q_addr [$];
  logic [DW-1:0] q_data [$];
  logic [3:0]    exp_sel;
  logic          mon_en;
  logic          have_held;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per accepted write, checks stall stability
  // and the lane select order.
  initial begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (have_held) begin
          check("stall_valid", {31'd0, wr_valid}, 32'd1);
          check("stall_addr", {22'd0, wr_addr}, {22'd0, held_addr});
          check("stall_data", {16'd0, wr_data}, {16'd0, held_data});
          have_held = 1'b0;
        end
        if (wr_valid && wr_ready) begin
          if (q_addr.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
          end else begin
            ea = q_addr.pop_front();
            ed = q_data.pop_front();
            check("wr_addr", {22'd0, wr_addr}, {22'd0, ea});
            check("wr_data", {16'd0, wr_data}, {16'd0, ed});
          end
        end else if (wr_valid) begin
          have_held = 1'b1;
          held_addr = wr_addr;
          held_data = wr_data;
        end
        if (mux_sel != 4'd0) begin
          check("mux_sel_order", {28'd0, mux_sel}, {28'd0, exp_sel});
          exp_sel = exp_sel + 4'd1;
        end
      end
    end
  end

  // mode 0: ready always high; 1: random ready; 2: three stall cycles on lane 4.
  task automatic run_pass(input logic [AW-1:0] base, input logic relu, input int mode, input bit restart);
    int cycle;
    int done_cyc;
    int stall;
    logic [AW-1:0] lane4;
    for (int i = 0; i < 8; i++) begin
      q_addr.push_back(base + AW'(i));
      q_data.push_back((relu && lanes[i][DW-1]) ? 16'h0000 : lanes[i]);
    end
    exp_sel  = 4'd1;
    stall    = 0;
    lane4    = base + 10'd3;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    relu_en   = relu;
    wr_ready  = 1'b1;
    cycle     = 0;
    done_cyc  = 0;
    while (done_cyc == 0 && cycle < 400) begin
      @(negedge clk);
      cycle++;
      start = 1'b0;
      if (restart && cycle == 5) begin
        start     = 1'b1;
        base_addr = 10'h100;
        relu_en   = ~relu;
      end
      case (mode)
        1: wr_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (wr_valid && wr_addr == lane4 && stall < 3) begin
            wr_ready = 1'b0;
            stall++;
          end else begin
            wr_ready = 1'b1;
          end
        end
        default: wr_ready = 1'b1;
      endcase
      #1;
      check("busy_in_pass", {31'd0, busy}, 32'd1);
      if (done) done_cyc = cycle;
    end
    if (done_cyc == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end else if (mode != 1) begin
      check("done_cycle", done_cyc, (mode == 2) ? 32'd20 : 32'd17);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_after", {31'd0, busy}, 32'd0);
    check("done_after", {31'd0, done}, 32'd0);
    check("writes_left", q_addr.size(), 32'd0);
    check("lanes_fetched", {28'd0, exp_sel}, 32'd9);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mux_sel"}, {28'd0, mux_sel}, 32'd0);
    check({tag, "_wr_valid"}, {31'd0, wr_valid}, 32'd0);
    check({tag, "_wr_addr"}, {22'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {16'd0, wr_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int found;
    logic [15:0] pat [4];
    pat[0] = 16'hFFFF; pat[1] = 16'h0000; pat[2] = 16'h8000; pat[3] = 16'h7FFF;
    rst = 1'b1; start = 1'b0; base_addr = '0; relu_en = 1'b0; wr_ready = 1'b1;
    mon_en = 1'b0; have_held = 1'b0; exp_sel = 4'd1;
    for (int i = 0; i < 8; i++) lanes[i] = 16'(16'h0010 * (i + 1));
    repeat (2) @(negedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    run_pass(10'h020, 1'b0, 0, 1'b0);
    run_pass(10'h020, 1'b0, 2, 1'b0);
    for (int i = 0; i < 8; i++) lanes[i] = pat[i % 4];
    run_pass(10'h040, 1'b1, 0, 1'b0);
    run_pass(10'h040, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) lanes[i] = 16'(i + 1);
    run_pass(10'h3FE, 1'b0, 0, 1'b1);

    // Reset while lane 5's write is pending.
    for (int i = 0; i < 8; i++) begin
      q_addr.push_back(10'h200 + AW'(i));
      q_data.push_back(lanes[i]);
    end
    exp_sel = 4'd1;
    @(negedge clk);
    start = 1'b1; base_addr = 10'h200; relu_en = 1'b0; wr_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (wr_valid && wr_addr == 10'h204) found = 1;
    end
    if (found == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL reset_setup: got no lane 5 write expected one within 100 cycles");
    end
    mon_en = 1'b0;
    rst = 1'b1;
    wr_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wr_ready = 1'b1;
    #1;
    check_idle_zero("midreset");
    q_addr.delete();
    q_data.delete();
    repeat (3) begin
      @(negedge clk);
      #1;
      check("no_done_after_reset", {31'd0, done}, 32'd0);
      check("no_write_after_reset", {31'd0, wr_valid}, 32'd0);
    end
    have_held = 1'b0;
    mon_en = 1'b1;
    run_pass(10'h200, 1'b0, 0, 1'b0);

    // Randomised passes with random lanes, base, ReLU and backpressure.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 8; i++) lanes[i] = 16'($urandom);
      run_pass(10'($urandom), 1'($urandom), 1, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
